// File: rtl/snoop_command_controller.sv
// Command sequencer: decodes host UART bytes into snooper record/dump
// control and muxes two-byte replies with the snooper's dump stream.
// Ports:
//   comm_clock, comm_reset        clock, async active-high reset
//   cmd_valid/cmd_data/cmd_ready  UART RX byte stream
//   tx_valid/tx_data/tx_ready     UART TX byte stream (shared)
//   snoop_record_start/_end       record control, end is from cb_clk
//   snoop_dump_start/_end         dump control, comm_clock domain
//   snoop_out_valid/_data/_ready  snooper dump byte stream
//   busy                          high outside IDLE
module snoop_command_controller #(
  parameter logic [31:0] RECORD_TIMEOUT = 32'd50_000_000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic       comm_clock,
  input  logic       comm_reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       snoop_record_start,
  input  logic       snoop_record_end,
  output logic       snoop_dump_start,
  input  logic       snoop_dump_end,
  input  logic       snoop_out_valid,
  input  logic [7:0] snoop_out_data,
  output logic       snoop_out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_DUMP,
    S_GUARD,
    S_REPLY0,
    S_REPLY1
  } state_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_Q  = 8'h51;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_UN = 8'h3F;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  logic [7:0] c0_q, c0_d;
  logic [7:0] c1_q, c1_d;
  logic rec_q, rec_d;
  logic dmp_q, dmp_d;
  logic guard_q, guard_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic full;
  logic accept;
  logic is_ws;
  logic tmo_hit;
  logic go;
  logic [7:0] go_ch;
  state_t go_ret;

  assign full    = sync_q[SYNC_STAGES-1];
  assign accept  = cmd_valid && cmd_ready;
  assign is_ws   = (cmd_data == CH_LF) ||
                   (cmd_data == CH_CR) ||
                   (cmd_data == CH_SP);
  assign tmo_hit = (RECORD_TIMEOUT != 32'd0) &&
                   (tcnt_q == RECORD_TIMEOUT - 32'd1);

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_REC);
  assign busy      = (state_q != S_IDLE);
  assign snoop_record_start = rec_q;
  assign snoop_dump_start   = dmp_q;

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], snoop_record_end};
    end
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      c0_q    <= 8'h00;
      c1_q    <= 8'h00;
      rec_q   <= 1'b0;
      dmp_q   <= 1'b0;
      guard_q <= 1'b0;
      tcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      rec_q   <= rec_d;
      dmp_q   <= dmp_d;
      guard_q <= guard_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    snoop_out_ready = 1'b0;
    unique case (state_q)
      S_REPLY0: begin
        tx_valid = 1'b1;
        tx_data  = c0_q;
      end
      S_REPLY1: begin
        tx_valid = 1'b1;
        tx_data  = c1_q;
      end
      S_DUMP: begin
        tx_valid        = snoop_out_valid;
        tx_data         = snoop_out_data;
        snoop_out_ready = tx_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    rec_d   = rec_q;
    dmp_d   = dmp_q;
    guard_d = guard_q;
    tcnt_d  = tcnt_q;
    go      = 1'b0;
    go_ch   = CH_UN;
    go_ret  = S_IDLE;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !is_ws) begin
          unique case (1'b1)
            (cmd_data == CH_R): begin
              go     = 1'b1;
              go_ch  = CH_K;
              go_ret = S_REC;
              rec_d  = 1'b1;
              tcnt_d = 32'd0;
            end
            (cmd_data == CH_D): begin
              state_d = S_GUARD;
              dmp_d   = 1'b1;
              guard_d = 1'b0;
            end
            (cmd_data == CH_Q): begin
              go    = 1'b1;
              go_ch = CH_I;
            end
            default: begin
              go = 1'b1;
            end
          endcase
        end
      end
      S_REC: begin
        // Saturate; holding at the trip value lets a timeout that
        // lost to a command fire once recording resumes.
        if (!tmo_hit && (tcnt_q != 32'hFFFF_FFFF)) begin
          tcnt_d = tcnt_q + 32'd1;
        end
        if (accept && !is_ws) begin
          go_ret = S_REC;
          unique case (1'b1)
            (cmd_data == CH_S): begin
              go     = 1'b1;
              go_ch  = CH_K;
              go_ret = S_IDLE;
              rec_d  = 1'b0;
            end
            (cmd_data == CH_Q): begin
              go    = 1'b1;
              go_ch = CH_B;
            end
            default: begin
              go = 1'b1;
            end
          endcase
        end else if (full) begin
          go    = 1'b1;
          go_ch = CH_F;
          rec_d = 1'b0;
        end else if (tmo_hit) begin
          go    = 1'b1;
          go_ch = CH_T;
          rec_d = 1'b0;
        end
      end
      S_GUARD: begin
        // Two cycles hide the dump_end left over from a previous dump.
        if (guard_q) begin
          state_d = S_DUMP;
        end else begin
          guard_d = 1'b1;
        end
      end
      S_DUMP: begin
        if (snoop_dump_end && !snoop_out_valid) begin
          go    = 1'b1;
          go_ch = CH_E;
          dmp_d = 1'b0;
        end
      end
      S_REPLY0: begin
        if (tx_ready) begin
          state_d = S_REPLY1;
        end
      end
      S_REPLY1: begin
        if (tx_ready) begin
          state_d = ret_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (go) begin
      state_d = S_REPLY0;
      c0_d    = go_ch;
      c1_d    = CH_LF;
      ret_d   = go_ret;
    end
  end

endmodule

// File: tb/tb_snoop_command_controller.sv
// Bench for snoop_command_controller: directed and random command
// streams against a reply-level model, with a model snooper.
module tb_snoop_command_controller;

  localparam logic [31:0] TMO = 32'd20;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [7:0] cmd_data;
  logic cmd_ready;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  logic snoop_record_start;
  logic snoop_record_end;
  logic snoop_dump_start;
  logic snoop_dump_end;
  logic snoop_out_valid;
  logic [7:0] snoop_out_data;
  logic snoop_out_ready;
  logic busy;

  always #5 clk = ~clk;

  snoop_command_controller #(
    .RECORD_TIMEOUT(TMO),
    .SYNC_STAGES(SS)
  ) dut (
    .comm_clock(clk),
    .comm_reset(rst),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .snoop_record_start(snoop_record_start),
    .snoop_record_end(snoop_record_end),
    .snoop_dump_start(snoop_dump_start),
    .snoop_dump_end(snoop_dump_end),
    .snoop_out_valid(snoop_out_valid),
    .snoop_out_data(snoop_out_data),
    .snoop_out_ready(snoop_out_ready),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic cmd_pend = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  int rdy_mode = 0;
  logic [7:0] rx[$];
  logic [7:0] sq[$];
  logic snp_en = 1'b0;
  string exp_s;
  string dump_txt;
  logic m_rec = 1'b0;
  logic dump_pend = 1'b0;
  int dcnt = -1;
  int guard_bad = 0;
  int both_bad = 0;
  int dump_rdy_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string mdl(input logic [7:0] b);
    if (b == 8'h0A || b == 8'h0D || b == 8'h20) return "";
    if (!m_rec) begin
      if (b == "R") begin
        m_rec = 1'b1;
        return "K\n";
      end
      if (b == "D") return {dump_txt, "E\n"};
      if (b == "Q") return "I\n";
      return "?\n";
    end
    if (b == "S") begin
      m_rec = 1'b0;
      return "K\n";
    end
    if (b == "Q") return "B\n";
    return "?\n";
  endfunction

  task automatic cyc();
    @(negedge clk);
    cmd_valid = cmd_pend;
    cmd_data  = cmd_byte;
    if (rdy_mode == 1) tx_ready = 1'b1;
    else if (rdy_mode == 2) tx_ready = 1'b0;
    else tx_ready = 1'($urandom_range(0, 1));
    snoop_out_valid = snoop_dump_start && (sq.size() > 0) &&
                      ($urandom_range(0, 3) != 0);
    snoop_out_data = (sq.size() > 0) ? sq[0] : 8'h00;
    snoop_dump_end = snp_en && (sq.size() == 0);
    #1;
    if (dcnt >= 0 && dcnt < 10) dcnt++;
    if ((dcnt == 1 || dcnt == 2) &&
        (tx_valid || snoop_out_ready || !snoop_dump_start))
      guard_bad++;
    if (snoop_record_start && snoop_dump_start) both_bad++;
    if (snoop_dump_start && cmd_ready) dump_rdy_bad++;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (snoop_out_valid && snoop_out_ready) void'(sq.pop_front());
    if (cmd_valid && cmd_ready) begin
      cmd_pend = 1'b0;
      if (dump_pend) begin
        dcnt = 0;
        dump_pend = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [7:0] b);
    dump_pend = (b == "D") && !m_rec;
    exp_s = mdl(b);
    rx.delete();
    cmd_byte = b;
    cmd_pend = 1'b1;
    for (int n = 0; n < 100 && cmd_pend; n++) cyc();
    chk("accept", 32'(cmd_pend), 32'd0);
  endtask

  task automatic wait_rx();
    for (int n = 0; n < 3000 && rx.size() < exp_s.len(); n++) cyc();
  endtask

  task automatic cmp(input string tag);
    cyc();
    cyc();
    chk({tag, "_len"}, 32'(rx.size()), 32'(exp_s.len()));
    for (int i = 0; i < exp_s.len() && i < rx.size(); i++)
      chk(tag, 32'(rx[i]), 32'(8'(exp_s[i])));
  endtask

  task automatic st_chk(input string tag);
    chk({tag, "_rec"}, 32'(snoop_record_start), 32'(m_rec));
    chk({tag, "_busy"}, 32'(busy), 32'(m_rec));
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_cmd(input logic [7:0] b, input string tag);
    issue(b);
    wait_rx();
    cmp(tag);
    st_chk(tag);
  endtask

  task automatic rst_chk(input string tag);
    chk(tag, 32'({cmd_ready, busy, tx_valid, snoop_record_start,
                  snoop_dump_start, snoop_out_ready, tx_data}),
        32'({6'b100000, 8'h00}));
  endtask

  initial begin
    string tbl;
    logic [7:0] b;
    int reccnt;
    logic was_rec;
    int cnt;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    tx_ready = 1'b0;
    snoop_record_end = 1'b0;
    snoop_dump_end = 1'b0;
    snoop_out_valid = 1'b0;
    snoop_out_data = 8'h00;
    #1;
    rst_chk("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_cmd("Q", "q_idle");

    rdy_mode = 2;
    issue("R");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (tx_valid && tx_data == 8'h4B && snoop_record_start) cnt++;
    end
    chk("r_hold", 32'(cnt), 32'd5);
    rdy_mode = 1;
    wait_rx();
    cmp("r_reply");
    st_chk("r_st");
    issue("S");
    cyc();
    chk("s_drop", 32'(snoop_record_start), 32'd0);
    wait_rx();
    cmp("s_reply");
    st_chk("s_st");

    rdy_mode = 0;
    do_cmd(8'h0D, "ws_cr");
    do_cmd(8'h20, "ws_sp");
    do_cmd("X", "unk");

    tbl = "RSQXDr\r \n";
    reccnt = 0;
    for (int k = 0; k < 30; k++) begin
      b = tbl[$urandom_range(0, 8)];
      if (!m_rec && b == "D") b = "Q";
      if (m_rec && reccnt >= 3) b = "S";
      if (m_rec) reccnt++;
      was_rec = m_rec;
      do_cmd(b, "rnd");
      if (!was_rec && m_rec) reccnt = 0;
    end
    if (m_rec) do_cmd("S", "rnd_s");

    rdy_mode = 1;
    issue("R");
    exp_s = "K\nT\n";
    cnt = 0;
    for (int n = 0; n < 200 && rx.size() < 4; n++) begin
      cyc();
      if (snoop_record_start) cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'd22);
    m_rec = 1'b0;
    cmp("tmo");
    st_chk("tmo_st");

    do_cmd("R", "f_r");
    rx.delete();
    snoop_record_end = 1'b1;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      cnt++;
      if (tx_valid) break;
    end
    chk("full_lat", 32'(cnt <= SS + 1), 32'd1);
    chk("full_chr", 32'(tx_data), 32'h46);
    m_rec = 1'b0;
    exp_s = "F\n";
    wait_rx();
    cmp("full");
    snoop_record_end = 1'b0;
    repeat (3) cyc();
    st_chk("full_st");

    rdy_mode = 0;
    dump_txt = "W00000010:0000BEEF\n";
    for (int i = 0; i < dump_txt.len(); i++) sq.push_back(dump_txt[i]);
    snp_en = 1'b1;
    do_cmd("D", "dump");
    chk("dump_start", 32'(snoop_dump_start), 32'd0);

    dump_txt = "";
    do_cmd("D", "dump_empty");
    chk("guard", 32'(guard_bad), 32'd0);
    chk("both_start", 32'(both_bad), 32'd0);
    chk("dump_rdy", 32'(dump_rdy_bad), 32'd0);

    for (int i = 0; i < 40; i++) sq.push_back(8'(65 + i));
    issue("D");
    for (int n = 0; n < 500 && rx.size() < 3; n++) cyc();
    chk("mid_dump", 32'(snoop_dump_start), 32'd1);
    #2 rst = 1'b1;
    #1 rst_chk("rst_dump");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sq.delete();
    dcnt = -1;
    cmd_pend = 1'b0;
    m_rec = 1'b0;
    do_cmd("Q", "post_dump");

    rdy_mode = 2;
    issue("Q");
    cyc();
    chk("r0_valid", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h49}));
    #2 rst = 1'b1;
    #1 rst_chk("rst_reply");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    do_cmd("Q", "post_reply");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_command_controller.md
Name: snoop_command_controller

Overview:
- Command sequencer between the host UART byte streams and computie_bus_snooper, all on comm_clock.
- Decodes single-byte ASCII commands and drives the snooper's record_start and dump_start.
- Owns the single UART transmit channel. It multiplexes its own two-byte replies with the snooper's hex dump stream.

Parameters:
RECORD_TIMEOUT, 32'd50_000_000, comm_clock cycles allowed in RECORDING before forced exit; 0 disables the timeout.
SYNC_STAGES, 2, flop stages used to synchronise snoop_record_end into comm_clock (minimum 2).

Ports:
comm_clock  input  1  system clock; all logic on its rising edge
comm_reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  UART RX byte available
cmd_data  input  8  UART RX byte
cmd_ready  output  1  command byte consumed when valid&&ready
tx_valid  output  1  UART TX byte valid
tx_data  output  8  UART TX byte
tx_ready  input  1  UART TX accepts byte when valid&&ready
snoop_record_start  output  1  level; high enables snooper recording
snoop_record_end  input  1  snooper buffer full, from the cb_clk domain
snoop_dump_start  output  1  level; high enables snooper dump
snoop_dump_end  input  1  snooper dump complete, comm_clock domain
snoop_out_valid  input  1  snooper dump byte valid
snoop_out_data  input  8  snooper dump byte
snoop_out_ready  output  1  back-pressure to snooper
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; every output 0 except cmd_ready=1; timeout counter 0; reply registers cleared.
  - Reset mid-record or mid-dump drops both start levels immediately; any reply in flight is abandoned.
- States: IDLE, RECORDING, DUMPING, DUMP_GUARD, REPLY0, REPLY1.
  - REPLY0/REPLY1 hold {char0, char1, return_state}, all latched on entry.
- cmd_ready=1 only in IDLE and RECORDING; 0 elsewhere, so commands stall during replies and dumps.
- Command decode is case-sensitive; a byte is accepted on the cmd_valid&&cmd_ready edge.
  - 0x0A, 0x0D, 0x20: consumed silently; no state change.
  - IDLE 'R': reply "K\n", return to RECORDING; snoop_record_start=1 from the cycle REPLY0 is entered; timeout counter cleared.
  - IDLE 'D': enter DUMP_GUARD with snoop_dump_start=1.
  - 'Q': reply "I\n" in IDLE, "B\n" in RECORDING; return to the current state.
  - RECORDING 'S': snoop_record_start=0 next cycle; reply "K\n", return IDLE.
  - Any other byte, or 'R'/'D' while in RECORDING: reply "?\n", return to the current state; record_start is unchanged.
- RECORDING exit priority when events coincide in one cycle: accepted command, then full, then timeout.
  - Full = synchronised snoop_record_end high. Drop record_start; reply "F\n", return IDLE.
  - Timeout: counter increments every RECORDING cycle and saturates. When counter==RECORD_TIMEOUT-1 (RECORD_TIMEOUT!=0), drop record_start; reply "T\n", return IDLE.
  - The counter is held (not cleared) while in REPLY states that return to RECORDING.
- Reply output:
  - REPLY0: tx_valid=1, tx_data=char0. On tx_ready go to REPLY1.
  - REPLY1: tx_data=char1. On tx_ready go to return_state.
  - tx_data is stable while tx_valid&&!tx_ready. Latency from command accept to tx_valid is 1 cycle.
- Dumping:
  - DUMP_GUARD lasts exactly 2 cycles with tx_valid=0 and snoop_out_ready=0, masking the stale registered dump_end; then enter DUMPING.
  - DUMPING is a combinational pass-through: tx_valid=snoop_out_valid, tx_data=snoop_out_data, snoop_out_ready=tx_ready.
  - When snoop_dump_end=1 and snoop_out_valid=0: snoop_dump_start=0 next cycle; reply "E\n", return IDLE.
  - If dump_end and out_valid are both high, finish the byte first.
  - An empty buffer (dump_end high straight after the guard) yields only "E\n".
- snoop_record_start and snoop_dump_start are registered and never high together.

Test Plan:
- Reset, send 'Q' -> tx "I\n" (0x49, 0x0A); busy=0 afterwards; cmd_ready=1.
- 'R' with tx_ready held low 5 cycles -> tx_data=0x4B stable for all 5 cycles; record_start=1 from the cycle after accept; then 'S' -> "K\n", record_start=0 the cycle after 'S' is accepted.
- RECORD_TIMEOUT=20, 'R', no 'S' -> record_start low after 20 RECORDING cycles, tx "T\n"; assert snoop_record_end instead -> "F\n" within SYNC_STAGES+1 cycles.
- 'D' with a model snooper emitting "W00000010:0000BEEF\n" under random tx_ready -> identical byte sequence on tx, then "E\n"; dump_start low; cmd_ready=0 throughout.
- 'D' with dump_end already high -> guard masks it for 2 cycles, then only "E\n"; 'X' in IDLE -> "?\n"; bytes 0x0D/0x20 -> no tx activity.
- comm_reset asserted mid-dump and mid-REPLY0 -> all outputs 0 asynchronously; state IDLE after release.
